// File: rtl/mvau_defn.sv
// Shared MVAU definitions: sequencing state and folding-factor helpers,
// used by the input-buffer controller and the weight-memory controller.
package mvau_defn;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } mvau_state_e;

    // Synapse fold: stream words per input vector
    function automatic int calc_sf(input int matrix_w, input int simd);
        return matrix_w / simd;
    endfunction

    // Neuron fold: number of PE row groups
    function automatic int calc_nf(input int matrix_h, input int pe);
        return matrix_h / pe;
    endfunction

    // Counter width that stays at least one bit for a single-value range
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvau_wrap_cnt.sv
// Modulo-MAX counter: counts 0..MAX-1 on en and wraps back to zero.
module mvau_wrap_cnt
    import mvau_defn::*;
#(
    parameter  int MAX = 4,
    localparam int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_last
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: advance on enable, wrap after the last value
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = {W{1'b0}};
            end else begin
                cnt_d = cnt_q + W'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_last = (cnt_q == LAST);

endmodule

// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input-activation buffer sequencer. The first pass of a vector is
// forwarded from the input stream and written to the buffer; the remaining
// NF-1 passes are replayed from the buffer. All outputs are combinational
// decodes of the registered state so the controller adds no latency.
module mvau_inp_buf_ctrl
    import mvau_defn::*;
#(
    parameter  int MatrixW  = 20,
    parameter  int MatrixH  = 20,
    parameter  int SIMD     = 2,
    parameter  int PE       = 2,
    localparam int SF       = calc_sf(MatrixW, SIMD),
    localparam int NF       = calc_nf(MatrixH, PE),
    localparam int BUF_ADDR = $clog2(SF),
    localparam int NF_W     = cnt_width(NF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_v,
    output logic                in_rdy,
    input  logic                out_rdy,
    output logic                out_v,
    output logic                write_en,
    output logic                read_en,
    output logic [BUF_ADDR-1:0] addr,
    output logic                sf_first,
    output logic                sf_last,
    output logic [NF_W-1:0]     nf_idx,
    output logic                vec_done
);

    localparam bit MULTI_NF = (NF > 1);

    mvau_state_e         state_q;
    mvau_state_e         state_d;
    logic                xfer_s;
    logic [BUF_ADDR-1:0] sf_cnt_s;
    logic                sf_last_s;
    logic [NF_W-1:0]     nf_cnt_s;
    logic                nf_last_s;

    // Word position within the vector; advances on every transfer
    mvau_wrap_cnt #(.MAX(SF)) u_sf_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (xfer_s),
        .cnt     (sf_cnt_s),
        .at_last (sf_last_s)
    );

    // Row-group index; advances when the last word of a pass transfers
    mvau_wrap_cnt #(.MAX(NF)) u_nf_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (xfer_s && sf_last_s),
        .cnt     (nf_cnt_s),
        .at_last (nf_last_s)
    );

    // State register; reset discards any partially filled vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave FILL after the last stored word, return after the last replay
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (xfer_s && sf_last_s && MULTI_NF) begin
                    state_d = REPLAY;
                end else begin
                    state_d = FILL;
                end
            end
            REPLAY: begin
                if (xfer_s && sf_last_s && nf_last_s) begin
                    state_d = FILL;
                end else begin
                    state_d = REPLAY;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Handshake and buffer-port decode; write only when the word is also forwarded
    always_comb begin
        in_rdy   = 1'b0;
        out_v    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        case (state_q)
            FILL: begin
                in_rdy   = out_rdy;
                out_v    = in_v;
                write_en = in_v && out_rdy;
                read_en  = 1'b0;
            end
            REPLAY: begin
                in_rdy   = 1'b0;
                out_v    = 1'b1;
                write_en = 1'b0;
                read_en  = 1'b1;
            end
            default: begin
                in_rdy   = 1'b0;
                out_v    = 1'b0;
                write_en = 1'b0;
                read_en  = 1'b0;
            end
        endcase
    end

    assign xfer_s   = out_v && out_rdy;
    assign addr     = sf_cnt_s;
    assign sf_first = (sf_cnt_s == {BUF_ADDR{1'b0}});
    assign sf_last  = sf_last_s;
    assign nf_idx   = nf_cnt_s;
    assign vec_done = xfer_s && sf_last_s && nf_last_s;

endmodule

// File: doc/mvau_inp_buf_ctrl.md
Name: mvau_inp_buf_ctrl

Overview:
- Sequencer for the MVAU input-activation buffer.
- Consumes one input vector of SF = MatrixW/SIMD stream words while forwarding them to the compute stage and writing them into the buffer.
- Then replays the buffered words NF−1 more times, so the vector is multiplied against every PE-row group of the weight matrix.
- Drives the buffer's write_en, read_en and addr. Emits sf/nf position flags for the accumulator and weight-address logic.

Parameters:
- MatrixW, 20, lowered weight-matrix width (Kernel^2*IFMCh).
- MatrixH, 20, lowered weight-matrix height (OFMCh).
- SIMD, 2, input words per cycle; MatrixW % SIMD == 0, SF = MatrixW/SIMD >= 2.
- PE, 2, processing elements; MatrixH % PE == 0, NF = MatrixH/PE >= 1.
- BUF_ADDR, $clog2(SF), localparam, buffer address width.
- NF_W, max(1,$clog2(NF)), localparam, nf counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_v  in  1  upstream input word valid.
- in_rdy  out  1  upstream ready; a word is consumed when in_v && in_rdy.
- out_rdy  in  1  downstream (MAC stage) ready.
- out_v  out  1  buffer output word valid to downstream.
- write_en  out  1  buffer write enable.
- read_en  out  1  buffer read select (0 = bypass input, 1 = stored word).
- addr  out  BUF_ADDR  buffer address, shared by read and write.
- sf_first  out  1  current word is sf==0 (accumulator clear).
- sf_last  out  1  current word is sf==SF-1 (accumulator result valid).
- nf_idx  out  NF_W  current row-group index (weight-memory offset).
- vec_done  out  1  one-cycle pulse on the final transfer of a vector (sf==SF-1, nf==NF-1).

Behaviour:
- Reset: state=FILL, sf=0, nf=0. Combinationally this gives in_rdy=out_rdy, out_v=in_v, write_en=0 (while in_v=0), read_en=0, addr=0, sf_first=1, sf_last=0, nf_idx=0, vec_done=0.
- Reset mid-vector discards progress; the partially written buffer is not replayed.
- The buffer read is combinational, so all controller outputs are combinational decodes of the registered state/counters plus the handshake inputs. The controller adds zero latency.
- Transfer xfer = out_v && out_rdy. Counters advance only on xfer; otherwise everything holds.
- State FILL (nf==0):
  - read_en=0, in_rdy=out_rdy, out_v=in_v, write_en=in_v && out_rdy, addr=sf.
  - The input word is forwarded and stored in the same cycle.
- State REPLAY (nf>=1):
  - read_en=1, in_rdy=0, out_v=1, write_en=0, addr=sf.
- sf counter: on xfer, sf==SF-1 → sf=0; else sf+1.
- nf counter: on xfer with sf==SF-1, nf==NF-1 → nf=0; else nf+1.
- Transitions:
  - FILL→REPLAY on xfer && sf==SF-1 && NF>1.
  - REPLAY→FILL on xfer && sf==SF-1 && nf==NF-1.
  - With NF==1 the block stays in FILL permanently (pure pass-through plus write).
- Flags:
  - sf_first = (sf==0).
  - sf_last = (sf==SF-1).
  - nf_idx = nf.
  - vec_done = xfer && sf_last && nf==NF-1.
- Back-pressure: out_rdy=0 in FILL forces in_rdy=0 and write_en=0, so no word is written without being forwarded. Upstream must hold in_v/data (AXI-stream rule).
- Boundaries:
  - Back-to-back vectors: the first FILL word of vector k+1 may transfer the cycle after vec_done of vector k. No bubble is required.
  - Write and read never coincide (mutually exclusive by state).
  - SF not a power of two: addr wraps at SF-1, never reaches SF.
  - in_v toggling in FILL: counters hold on any cycle without xfer.

Decomposition:
- Shared package mvau_defn: state enum typedef (FILL, REPLAY) and SF/NF derivation helper functions, reused by the weight-memory controller.
- No sub-module. One generic wrap counter (mvau_wrap_cnt, parameter MAX) is natural and is instantiated twice, for sf and nf.

Test Plan (MatrixW=8, SIMD=2 → SF=4; MatrixH=6, PE=2 → NF=3 unless stated):
- Reset, then stream words A0..A3 with out_rdy=1 → write_en=1 with addr 0,1,2,3 and read_en=0. Then 8 replay cycles with read_en=1, addr 0,1,2,3,0,1,2,3. nf_idx goes 0→1→2. vec_done on cycle 12. in_rdy=0 during replay.
- Back-to-back vectors A then B, in_v always 1 → B0 is consumed on the cycle after A's vec_done. Exactly 12 xfers per vector and 2 vec_done pulses in 24 cycles.
- out_rdy held 0 for 3 cycles at FILL sf=2 and again at REPLAY sf=1 → write_en=0 and in_rdy=0 during the stall. addr and counters are frozen. Sequence resumes with no skipped or duplicated address.
- rst_n=0 for one cycle at REPLAY nf=1, sf=2 → next cycle is FILL with sf=0, nf=0 and in_rdy=out_rdy. The next accepted word writes addr 0.
- NF=1 configuration (MatrixH=2) → read_en never asserted. vec_done every 4 xfers. sf_first on addr 0, sf_last on addr 3.
- Gapped input (in_v=1 on alternate cycles) in FILL → exactly one write per valid word. No counter advance on gap cycles.
